// File: rtl/race_screen_fsm_if.sv
// Race sequencer bundle: button/game-status inputs, player positions,
// and the screen/gating outputs toward the strip renderer.
interface race_screen_fsm_if #(
  parameter int PW = 7
);
  logic          start_btn;
  logic          game_started;
  logic [PW-1:0] green_cur_pos;
  logic [PW-1:0] red_cur_pos;
  logic [PW-1:0] blue_cur_pos;
  logic [PW-1:0] yellow_cur_pos;
  logic          is_in_menu;
  logic          clear_positions;
  logic          players_enable;
  logic [1:0]    countdown_value;
  logic          winner_valid;
  logic [1:0]    winner_id;

  modport master (
    output start_btn,
    output game_started,
    output green_cur_pos,
    output red_cur_pos,
    output blue_cur_pos,
    output yellow_cur_pos,
    input  is_in_menu,
    input  clear_positions,
    input  players_enable,
    input  countdown_value,
    input  winner_valid,
    input  winner_id
  );

  modport slave (
    input  start_btn,
    input  game_started,
    input  green_cur_pos,
    input  red_cur_pos,
    input  blue_cur_pos,
    input  yellow_cur_pos,
    output is_in_menu,
    output clear_positions,
    output players_enable,
    output countdown_value,
    output winner_valid,
    output winner_id
  );
endinterface

// File: rtl/race_screen_fsm.sv
// Race sequencer: menu -> countdown -> race -> finish -> menu.
// All outputs come straight from flops.
module race_screen_fsm #(
  parameter int MAX_POS         = 109,
  parameter int COUNTDOWN_STEPS = 3,
  parameter int TICKS_PER_STEP  = 50_000_000,
  parameter int FINISH_TICKS    = 150_000_000
) (
  input logic              clk,
  input logic              reset,
  race_screen_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_COUNT  = 2'd1,
    S_RACE   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int MAXT =
    (TICKS_PER_STEP > FINISH_TICKS) ? TICKS_PER_STEP : FINISH_TICKS;
  localparam int CW = $clog2(MAXT);
  localparam int END_POS = MAX_POS - 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(TICKS_PER_STEP - 1);
  localparam logic [CW-1:0] FIN_LAST  = CW'(FINISH_TICKS - 1);
  localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_STEPS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cd_q, cd_d;
  logic          clr_q, clr_d;
  logic          wv_q, wv_d;
  logic [1:0]    wid_q, wid_d;
  logic          menu_q, menu_d;
  logic          en_q, en_d;
  logic          start_q;
  logic          armed_q;

  logic          start_rise;
  logic [3:0]    at_end;
  logic [1:0]    win_sel;

  // armed_q masks the first cycle after reset so a button held
  // through reset release is not seen as a fresh press.
  assign start_rise = armed_q & bus.start_btn & ~start_q;

  assign at_end[0] = int'(bus.green_cur_pos)  >= END_POS;
  assign at_end[1] = int'(bus.red_cur_pos)    >= END_POS;
  assign at_end[2] = int'(bus.blue_cur_pos)   >= END_POS;
  assign at_end[3] = int'(bus.yellow_cur_pos) >= END_POS;

  always_comb begin
    win_sel = 2'd0;
    if (at_end[0])      win_sel = 2'd0;
    else if (at_end[1]) win_sel = 2'd1;
    else if (at_end[2]) win_sel = 2'd2;
    else if (at_end[3]) win_sel = 2'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_MENU;
      cnt_q   <= '0;
      cd_q    <= 2'd0;
      clr_q   <= 1'b0;
      wv_q    <= 1'b0;
      wid_q   <= 2'd0;
      menu_q  <= 1'b1;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      clr_q   <= clr_d;
      wv_q    <= wv_d;
      wid_q   <= wid_d;
      menu_q  <= menu_d;
      en_q    <= en_d;
      start_q <= bus.start_btn;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cd_d    = cd_q;
    clr_d   = 1'b0;
    wv_d    = wv_q;
    wid_d   = wid_q;
    case (state_q)
      S_MENU: begin
        if (start_rise) begin
          state_d = S_COUNT;
          cnt_d   = '0;
          cd_d    = CD_INIT;
          clr_d   = 1'b1;
          wv_d    = 1'b0;
          wid_d   = 2'd0;
        end
      end
      S_COUNT: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (cd_q == 2'd1) begin
            state_d = S_RACE;
            cd_d    = 2'd0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RACE: begin
        // game_started low without anyone at the end is a glitch
        if (!bus.game_started && (|at_end)) begin
          state_d = S_FINISH;
          wv_d    = 1'b1;
          wid_d   = win_sel;
          cnt_d   = '0;
        end
      end
      S_FINISH: begin
        if (cnt_q == FIN_LAST) begin
          state_d = S_MENU;
          cnt_d   = '0;
          wv_d    = 1'b0;
          wid_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_MENU;
        cnt_d   = '0;
        cd_d    = 2'd0;
        wv_d    = 1'b0;
        wid_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    menu_d = (state_d == S_MENU);
    en_d   = (state_d == S_RACE);
  end

  assign bus.is_in_menu      = menu_q;
  assign bus.clear_positions = clr_q;
  assign bus.players_enable  = en_q;
  assign bus.countdown_value = cd_q;
  assign bus.winner_valid    = wv_q;
  assign bus.winner_id       = wid_q;

endmodule
